shift_add_sequencer: RTL and testbench
======================================

Name: shift_add_sequencer

Overview:
- Control and adder stage of the sequential shift-and-add unsigned multiplier.
- Sits directly upstream of the product register: drives the register's data input (Product_Sum) and its clear input (Clear_Product), and takes the register output back as Product_Feedback.
- Captures operands on a start request and sequences Word_Length add/shift cycles.
- Latches the final product into Result and pulses done.

Parameters:
- Word_Length, 8, operand width W in bits; legal range W >= 2; product width is 2W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a multiplication; sampled only in IDLE.
- Multiplicand  input  W  operand A (unsigned), captured when start is accepted.
- Multiplier  input  W  operand B (unsigned), captured when start is accepted.
- Product_Feedback  input  2W  current product register value.
- Product_Sum  output  2W  next value for the product register (combinational).
- Clear_Product  output  1  high = product register clears to 0 at the next edge.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  registered one-cycle pulse: Result holds a new product.
- Result  output  2W  registered final product; holds until the next completion.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port named reset.
- Reset values:
  - state = IDLE; Result = 0; done = 0; count = 0; operand shift registers = 0.
  - Combinational outputs during reset: busy = 0, Clear_Product = 0.
- Internal registers:
  - mcand_sh (2W): A zero-extended.
  - mplier_sh (W): B.
  - count: $clog2(W+1) bits.
- FSM states: IDLE, LOAD, RUN, DONE. busy = (state != IDLE).
- IDLE:
  - Product_Sum = Product_Feedback (hold); Clear_Product = 0.
  - If start = 1: capture operands, go to LOAD.
  - start = 0: remain in IDLE.
- LOAD (1 cycle):
  - Clear_Product = 1; Product_Sum = Product_Feedback (don't-care, register clears).
  - Next state RUN, count <= 0.
- RUN (exactly W cycles):
  - Product_Sum = Product_Feedback + (mplier_sh[0] ? mcand_sh : 0), computed mod 2^(2W). No overflow is possible for unsigned W-bit operands.
  - Each edge: mcand_sh <<= 1 (zero fill), mplier_sh >>= 1 (zero fill), count++.
  - When count == W-1 at the edge: go to DONE.
  - No early termination: latency is fixed regardless of operand values.
- DONE (1 cycle):
  - Product_Sum = Product_Feedback (hold); Clear_Product = 0.
  - At the edge: Result <= Product_Feedback, done <= 1, state <= IDLE.
- done is high for exactly the cycle after DONE, then 0 (unless re-set by a later completion).
- Latency: start sampled high in cycle n gives:
  - LOAD at n+1.
  - RUN at n+2 .. n+W+1.
  - DONE at n+W+2.
  - done = 1 and Result valid at n+W+3.
  - busy is high in cycles n+1 .. n+W+2.
- start while busy: ignored, no effect on operands or sequence.
- start in the done cycle: accepted, because state is IDLE; Result stays stable until the next completion.
- Operands changing after capture: no effect.
- Reset mid-operation: immediate return to IDLE, Result = 0, done = 0. Any partial value left in the product register is harmless, because the next LOAD clears it.
- Reset polarity at top level: the downstream product register uses an active-low reset, so the top level ties its reset to the inverse of reset.

Test Plan (W = 8; the bench instantiates the product register with Product_Input = Product_Sum, Load_enable = Clear_Product, reset inverted):
- Basic product: reset pulse, then start=1 for one cycle with A=13, B=11 (cycle n) -> busy high in cycles n+1..n+10; done=1 only in cycle n+11; Result=16'h008F.
- Max operands: A=255, B=255 -> Result=16'hFE01 at n+11. Zero operand: A=0, B=200 -> Result=16'h0000; latency is still n+11.
- Busy lockout: A=3, B=5 started; at cycle n+4 drive start=1 with A=7, B=7 -> single done pulse, Result=16'h000F, no second done.
- Back-to-back: A=12, B=10, then start=1 again in the done cycle with A=2, B=9 -> first Result=16'h0078; second done exactly 11 cycles later with Result=16'h0012.
- Mid-operation reset: reset asserted in RUN at cycle n+5 -> busy=0, done=0, Result=0 immediately. A new run with A=6, B=7 -> Result=16'h002A with no contamination from the aborted run.
- Random sweep: 500 random operand pairs; each Result must equal A*B with latency exactly 11 cycles.

Source files
------------

// File: rtl/shift_add_sequencer.sv
// shift_add_sequencer
// Control and adder stage of a sequential shift-and-add unsigned multiplier.
// The product register lives downstream: this block drives its data input
// (Product_Sum) and clear (Clear_Product) and reads it back on
// Product_Feedback. The multiplication always takes a fixed Word_Length
// add/shift cycles regardless of operand values.
module shift_add_sequencer #(
  parameter int Word_Length = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [Word_Length-1:0]     Multiplicand,
  input  logic [Word_Length-1:0]     Multiplier,
  input  logic [2*Word_Length-1:0]   Product_Feedback,
  output logic [2*Word_Length-1:0]   Product_Sum,
  output logic                       Clear_Product,
  output logic                       busy,
  output logic                       done,
  output logic [2*Word_Length-1:0]   Result
);

  localparam int CNT_W = $clog2(Word_Length + 1);
  localparam int PW    = 2 * Word_Length;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(Word_Length - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_r;
  logic [PW-1:0]          mcand_sh_r;
  logic [Word_Length-1:0] mplier_sh_r;
  logic [CNT_W-1:0]       count_r;
  logic [PW-1:0]          result_r;
  logic                   done_r;

  // Sequencer FSM: operand capture, shift/count during RUN, result latch in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      mcand_sh_r  <= {PW{1'b0}};
      mplier_sh_r <= {Word_Length{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      result_r    <= {PW{1'b0}};
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mcand_sh_r  <= {{Word_Length{1'b0}}, Multiplicand};
            mplier_sh_r <= Multiplier;
            state_r     <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          done_r  <= 1'b0;
          count_r <= {CNT_W{1'b0}};
          state_r <= RUN;
        end
        RUN: begin
          done_r      <= 1'b0;
          mcand_sh_r  <= {mcand_sh_r[PW-2:0], 1'b0};
          mplier_sh_r <= {1'b0, mplier_sh_r[Word_Length-1:1]};
          count_r     <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (count_r == LAST_COUNT) begin
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          result_r <= Product_Feedback;
          done_r   <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Next product-register value and clear request, decoded from the current state.
  always_comb begin
    Product_Sum   = Product_Feedback;
    Clear_Product = 1'b0;
    case (state_r)
      IDLE: begin
        Product_Sum   = Product_Feedback;
        Clear_Product = 1'b0;
      end
      LOAD: begin
        Product_Sum   = Product_Feedback;
        Clear_Product = 1'b1;
      end
      RUN: begin
        Clear_Product = 1'b0;
        if (mplier_sh_r[0]) begin
          Product_Sum = Product_Feedback + mcand_sh_r;
        end else begin
          Product_Sum = Product_Feedback;
        end
      end
      DONE: begin
        Product_Sum   = Product_Feedback;
        Clear_Product = 1'b0;
      end
      default: begin
        Product_Sum   = Product_Feedback;
        Clear_Product = 1'b0;
      end
    endcase
  end

  assign busy   = (state_r != IDLE);
  assign done   = done_r;
  assign Result = result_r;

endmodule

// File: tb/tb_shift_add_sequencer.sv
// Directed and random self-checking bench for shift_add_sequencer (W = 8).
// A behavioural product register closes the loop around the sequencer.
module tb_shift_add_sequencer;

  localparam int W = 8;

  logic            clk;
  logic            reset;
  logic            start;
  logic [W-1:0]    Multiplicand;
  logic [W-1:0]    Multiplier;
  logic [2*W-1:0]  Product_Feedback;
  logic [2*W-1:0]  Product_Sum;
  logic            Clear_Product;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  Result;

  logic            prod_rst_n;
  logic [2*W-1:0]  prev_result;
  int              n_checks;
  int              n_errors;

  shift_add_sequencer #(.Word_Length(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .Multiplicand     (Multiplicand),
    .Multiplier       (Multiplier),
    .Product_Feedback (Product_Feedback),
    .Product_Sum      (Product_Sum),
    .Clear_Product    (Clear_Product),
    .busy             (busy),
    .done             (done),
    .Result           (Result)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign prod_rst_n = ~reset;

  // Downstream product register: active-low reset, clears when Clear_Product is high.
  always_ff @(posedge clk or negedge prod_rst_n) begin
    if (!prod_rst_n) begin
      Product_Feedback <= 16'h0000;
    end else if (Clear_Product) begin
      Product_Feedback <= 16'h0000;
    end else begin
      Product_Feedback <= Product_Sum;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a start request in the current cycle (cycle n).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start        = 1'b1;
    Multiplicand = a;
    Multiplier   = b;
  endtask

  // Walk cycles n+1..n+11 after an accepted start, checking busy, clear,
  // done, held Result and final Result. Optionally drives start again in
  // cycle n+inject_k. Operands are scrambled while busy.
  task automatic follow(input string tag, input logic [2*W-1:0] exp_prod,
                        input int inject_k, input logic [W-1:0] ia,
                        input logic [W-1:0] ib);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == inject_k) begin
        start        = 1'b1;
        Multiplicand = ia;
        Multiplier   = ib;
      end else begin
        start        = 1'b0;
        Multiplicand = W'($urandom_range(0, 255));
        Multiplier   = W'($urandom_range(0, 255));
      end
      check_eq({tag, "_busy"},  {31'd0, busy},          {31'd0, (k <= 10)});
      check_eq({tag, "_clear"}, {31'd0, Clear_Product}, {31'd0, (k == 1)});
      check_eq({tag, "_done"},  {31'd0, done},          {31'd0, (k == 11)});
      if (k == 11) begin
        check_eq({tag, "_result"}, {16'd0, Result}, {16'd0, exp_prod});
        prev_result = exp_prod;
      end else begin
        check_eq({tag, "_hold"}, {16'd0, Result}, {16'd0, prev_result});
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    prev_result  = 16'h0000;
    reset        = 1'b1;
    start        = 1'b0;
    Multiplicand = 8'd0;
    Multiplier   = 8'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_busy",   {31'd0, busy},          32'd0);
    check_eq("rst_done",   {31'd0, done},          32'd0);
    check_eq("rst_clear",  {31'd0, Clear_Product}, 32'd0);
    check_eq("rst_result", {16'd0, Result},        32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // Basic product and the cycle after done.
    issue(8'd13, 8'd11);
    follow("basic", 16'h008F, 0, 8'd0, 8'd0);
    @(negedge clk);
    check_eq("basic_done_low", {31'd0, done}, 32'd0);
    check_eq("basic_keep",     {16'd0, Result}, 32'h0000_008F);

    // Max operands and zero operand.
    issue(8'd255, 8'd255);
    follow("max", 16'hFE01, 0, 8'd0, 8'd0);
    issue(8'd0, 8'd200);
    follow("zero", 16'h0000, 0, 8'd0, 8'd0);

    // Start while busy is ignored.
    issue(8'd3, 8'd5);
    follow("lockout", 16'h000F, 4, 8'd7, 8'd7);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("lockout_no_second_done", {31'd0, done}, 32'd0);
      check_eq("lockout_idle",           {31'd0, busy}, 32'd0);
    end

    // Back-to-back: second start in the done cycle.
    issue(8'd12, 8'd10);
    follow("b2b_first", 16'h0078, 11, 8'd2, 8'd9);
    follow("b2b_second", 16'h0012, 0, 8'd0, 8'd0);

    // Reset in the middle of RUN (cycle n+5).
    issue(8'd250, 8'd251);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_eq("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_busy",   {31'd0, busy},   32'd0);
    check_eq("mid_rst_done",   {31'd0, done},   32'd0);
    check_eq("mid_rst_result", {16'd0, Result}, 32'd0);
    prev_result = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    issue(8'd6, 8'd7);
    follow("after_rst", 16'h002A, 0, 8'd0, 8'd0);

    // Random sweep.
    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2*W-1:0] p;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      p = 16'(a) * 16'(b);
      issue(a, b);
      follow("rand", p, 0, 8'd0, 8'd0);
    end

    @(negedge clk);
    start = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
